// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, synchronous ROM interface, instruction register.
// Taken relative branches redirect fetch and squash the two in-flight wrong-path words.
module fetch_unit #(
    parameter int                     PC_WIDTH     = 8,
    parameter int                     INSTR_WIDTH  = 24,
    parameter int                     OFFSET_WIDTH = 8,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR    = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    hold,
    input  logic                    pc_rel_branch,
    input  logic [OFFSET_WIDTH-1:0] branch_offset,
    output logic [PC_WIDTH-1:0]     prog_addr,
    output logic                    prog_en,
    input  logic [INSTR_WIDTH-1:0]  prog_data,
    output logic [INSTR_WIDTH-1:0]  instr,
    output logic [5:0]              opcode,
    output logic                    instr_valid,
    output logic [PC_WIDTH-1:0]     pc
);

    typedef enum logic [1:0] {PRIME, RUN, FLUSH} state_t;

    state_t                  r_state,       w_state_nxt;
    logic [PC_WIDTH-1:0]     r_fetch_pc,    w_fetch_pc_nxt;
    logic [PC_WIDTH-1:0]     r_data_addr,   w_data_addr_nxt;
    logic [PC_WIDTH-1:0]     r_pc,          w_pc_nxt;
    logic [INSTR_WIDTH-1:0]  r_instr,       w_instr_nxt;
    logic                    r_instr_valid, w_instr_valid_nxt;
    logic [PC_WIDTH-1:0]     w_offset_ext;
    logic                    w_take;

    assign w_offset_ext = PC_WIDTH'(signed'(branch_offset));
    assign w_take       = pc_rel_branch && r_instr_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= PRIME;
            r_fetch_pc    <= '0;
            r_data_addr   <= '0;
            r_pc          <= '0;
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_data_addr   <= w_data_addr_nxt;
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
        end
    end

    // hold keeps every default, so the whole pipeline freezes in lockstep with the ROM
    always_comb begin
        w_state_nxt       = r_state;
        w_fetch_pc_nxt    = r_fetch_pc;
        w_data_addr_nxt   = r_data_addr;
        w_pc_nxt          = r_pc;
        w_instr_nxt       = r_instr;
        w_instr_valid_nxt = r_instr_valid;
        if (!hold) begin
            case (r_state)
                PRIME, FLUSH: begin
                    // prog_data is stale or wrong-path here; restart the stream at fetch_pc
                    w_instr_nxt       = NOP_INSTR;
                    w_instr_valid_nxt = 1'b0;
                    w_data_addr_nxt   = r_fetch_pc;
                    w_fetch_pc_nxt    = r_fetch_pc + PC_WIDTH'(1);
                    w_state_nxt       = RUN;
                end
                RUN: begin
                    if (w_take) begin
                        w_fetch_pc_nxt    = r_pc + w_offset_ext;
                        w_instr_nxt       = NOP_INSTR;
                        w_instr_valid_nxt = 1'b0;
                        w_state_nxt       = FLUSH;
                    end else begin
                        w_instr_nxt       = prog_data;
                        w_instr_valid_nxt = 1'b1;
                        w_pc_nxt          = r_data_addr;
                        w_data_addr_nxt   = r_fetch_pc;
                        w_fetch_pc_nxt    = r_fetch_pc + PC_WIDTH'(1);
                    end
                end
                default: w_state_nxt = PRIME;
            endcase
        end
    end

    assign prog_addr   = r_fetch_pc;
    assign prog_en     = !hold && !reset;
    assign instr       = r_instr;
    assign opcode      = r_instr[INSTR_WIDTH-1 -: 6];
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a 256-word synchronous ROM model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;
    logic        pc_rel_branch;
    logic [7:0]  branch_offset;
    logic [7:0]  prog_addr;
    logic        prog_en;
    logic [23:0] prog_data;
    logic [23:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [7:0]  pc;

    logic [23:0] mem [256];
    int          n_tot = 0;
    int          n_bad = 0;

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .hold          (hold),
        .pc_rel_branch (pc_rel_branch),
        .branch_offset (branch_offset),
        .prog_addr     (prog_addr),
        .prog_en       (prog_en),
        .prog_data     (prog_data),
        .instr         (instr),
        .opcode        (opcode),
        .instr_valid   (instr_valid),
        .pc            (pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (prog_en) prog_data <= mem[prog_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input string tag, input int a);
        logic [7:0]  addr;
        logic [23:0] w;
        addr = 8'(a);
        w    = mem[addr];
        check({tag, ".valid"},  32'(instr_valid), 32'd1);
        check({tag, ".instr"},  32'(instr), 32'(w));
        check({tag, ".pc"},     32'(pc), 32'(addr));
        check({tag, ".opcode"}, 32'(opcode), 32'(w[23:18]));
    endtask

    task automatic expect_bubble(input string tag);
        check({tag, ".valid"}, 32'(instr_valid), 32'd0);
        check({tag, ".instr"}, 32'(instr), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 24'(i + 'h100);
        mem[9] = 24'hA40109;  // non-zero opcode field (0x29) at the branch target
        reset = 1'b1; hold = 1'b0; pc_rel_branch = 1'b0; branch_offset = 8'h00;
        #12;
        check("rst.instr", 32'(instr), 32'd0);
        check("rst.valid", 32'(instr_valid), 32'd0);
        check("rst.pc", 32'(pc), 32'd0);
        check("rst.addr", 32'(prog_addr), 32'd0);
        check("rst.en", 32'(prog_en), 32'd0);
        check("rst.opc", 32'(opcode), 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("run.en", 32'(prog_en), 32'd1);

        // two-edge prime, then sequential words
        step(); expect_bubble("prime");
        step(); expect_word("seq0", 0);
        step(); expect_word("seq1", 1);
        step(); expect_word("seq2", 2);
        step(); expect_word("seq3", 3);

        // hold at pc=3: nothing moves, ROM disabled
        hold = 1'b1; #1;
        check("hold.en", 32'(prog_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_word("hold", 3);
            check("hold.addr", 32'(prog_addr), 32'd5);
        end
        hold = 1'b0;
        step(); expect_word("unhold4", 4);
        step(); expect_word("seq5", 5);

        // forward branch +4 from pc=5; a branch raised during FLUSH is ignored
        pc_rel_branch = 1'b1; branch_offset = 8'd4;
        step(); expect_bubble("fwd.b1");
        branch_offset = 8'd40;
        step(); expect_bubble("fwd.b2");
        pc_rel_branch = 1'b0;
        step(); expect_word("fwd.tgt", 9);
        step(); expect_word("fwd.nxt", 10);

        // backward branch -8 to reach pc=2
        pc_rel_branch = 1'b1; branch_offset = 8'hF8;
        step(); expect_bubble("back.b1");
        pc_rel_branch = 1'b0;
        step(); expect_bubble("back.b2");
        step(); expect_word("back.tgt", 2);

        // -4 from pc=2 wraps to 254, then increment wraps 255 -> 0
        pc_rel_branch = 1'b1; branch_offset = 8'hFC;
        step(); expect_bubble("wrap.b1");
        pc_rel_branch = 1'b0;
        step(); expect_bubble("wrap.b2");
        step(); expect_word("wrap.254", 254);
        step(); expect_word("wrap.255", 255);
        step(); expect_word("wrap.0", 0);

        // branch raised under hold: deferred, then taken exactly once
        hold = 1'b1; pc_rel_branch = 1'b1; branch_offset = 8'h10;
        step(); expect_word("hbr.h1", 0);
        step(); expect_word("hbr.h2", 0);
        check("hbr.addr", 32'(prog_addr), 32'd2);
        hold = 1'b0;
        step(); expect_bubble("hbr.b1");
        pc_rel_branch = 1'b0;
        step(); expect_bubble("hbr.b2");
        step(); expect_word("hbr.tgt", 16);
        step(); expect_word("hbr.nxt", 17);

        // reset while in FLUSH clears everything immediately
        pc_rel_branch = 1'b1; branch_offset = 8'd3;
        step(); expect_bubble("rflush.b1");
        pc_rel_branch = 1'b0;
        check("rflush.addr_pre", 32'(prog_addr), 32'd20);
        reset = 1'b1; #1;
        check("rflush.instr", 32'(instr), 32'd0);
        check("rflush.valid", 32'(instr_valid), 32'd0);
        check("rflush.addr", 32'(prog_addr), 32'd0);
        check("rflush.pc", 32'(pc), 32'd0);
        check("rflush.en", 32'(prog_en), 32'd0);
        step();
        reset = 1'b0;
        step(); expect_bubble("rflush.prime");
        step(); expect_word("rflush.w0", 0);
        step(); expect_word("rflush.w1", 1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
